// File: rtl/i_tree_multi.sv
// ---------------------------------------------------------------------------
// i_tree_multi
//   Multi-channel isolation-tree anomaly detector. Each serial sensor channel
//   is deserialised (MSB first) into DATA_WIDTH-bit words. Completed words
//   wait in a one-deep holding register per channel. A round-robin arbiter
//   feeds them one at a time into a shared engine that walks a binary tree
//   held in a runtime-writable node table. The engine reports the number of
//   nodes visited and flags short paths as anomalies.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-low
//   sensor_data      serial bit per channel
//   sensor_valid     qualifies sensor_data per channel
//   cfg_we/cfg_addr/cfg_thr/cfg_leaf   node-table write port
//   cfg_ready        engine idle, node-table writes accepted
//   result_valid     one-cycle result pulse
//   result_ch        channel of the latest result (held)
//   result_len       path length of the latest result (held)
//   anomaly_detected result_valid & (result_len < ANOMALY_LEN)
//   overrun          sticky per-channel word-drop flag
//   dbg_state_o      engine FSM state (0 idle, 1 eval, 2 done)
//
// Handshake: a node-table write is taken at the rising edge where
// cfg_we && cfg_ready; with cfg_ready low the write is dropped, not stalled.
// result_valid is a single-cycle pulse with no back-pressure.
// ---------------------------------------------------------------------------
module i_tree_multi #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int TREE_DEPTH  = 4,
  parameter int ANOMALY_LEN = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CH-1:0]                   sensor_data,
  input  logic [NUM_CH-1:0]                   sensor_valid,
  input  logic                                cfg_we,
  input  logic [$clog2(2**TREE_DEPTH-1)-1:0]  cfg_addr,
  input  logic [DATA_WIDTH-1:0]               cfg_thr,
  input  logic                                cfg_leaf,
  output logic                                cfg_ready,
  output logic                                result_valid,
  output logic [$clog2(NUM_CH)-1:0]           result_ch,
  output logic [$clog2(TREE_DEPTH+1)-1:0]     result_len,
  output logic                                anomaly_detected,
  output logic [NUM_CH-1:0]                   overrun,
  output logic [1:0]                          dbg_state_o
);

  localparam int NODES = 2**TREE_DEPTH - 1;
  localparam int AW    = $clog2(NODES);
  localparam int CW    = $clog2(NUM_CH);
  localparam int LW    = $clog2(TREE_DEPTH + 1);
  localparam int BW    = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Deserialiser and holding registers
  logic [DATA_WIDTH-1:0] word_q [NUM_CH];
  logic [DATA_WIDTH-1:0] word_d [NUM_CH];
  logic [BW-1:0]         cnt_q  [NUM_CH];
  logic [BW-1:0]         cnt_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     ovr_q, ovr_d;

  // Node table
  logic [DATA_WIDTH-1:0] thr_q [NODES];
  logic [NODES-1:0]      leaf_q;

  // Engine datapath
  logic [DATA_WIDTH-1:0] eval_q, eval_d;
  logic [AW-1:0]         node_q, node_d;
  logic [LW-1:0]         len_q, len_d, len_inc;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         res_ch_q, res_ch_d;
  logic [LW-1:0]         res_len_q, res_len_d;

  logic                  gnt_found;
  logic [CW-1:0]         gnt_ch;
  logic                  grant;
  logic                  walk_end;
  logic                  cfg_hit;

  // Round-robin search: first pending channel strictly after ptr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!gnt_found && pend_q[c] && (((int'(ptr_q) + i) % NUM_CH) == c)) begin
          gnt_found = 1'b1;
          gnt_ch    = CW'(c);
        end
      end
    end
  end

  assign grant    = (state_q == S_IDLE) && gnt_found;
  assign len_inc  = len_q + LW'(1);
  assign walk_end = leaf_q[node_q] || (len_inc == LW'(TREE_DEPTH));
  assign cfg_hit  = cfg_we && cfg_ready && (int'(cfg_addr) < NODES);

  // Deserialisers. A grant clears pending before a same-cycle completion on
  // the same channel re-arms it, so the engine takes the old word and the new
  // one is kept without counting as an overrun.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      word_d[c] = word_q[c];
      cnt_d[c]  = cnt_q[c];
      hold_d[c] = hold_q[c];
      pend_d[c] = pend_q[c];
      ovr_d[c]  = ovr_q[c];
      if (grant && (gnt_ch == CW'(c))) begin
        pend_d[c] = 1'b0;
      end
      if (sensor_valid[c]) begin
        word_d[c] = {word_q[c][DATA_WIDTH-2:0], sensor_data[c]};
        if (cnt_q[c] == BW'(DATA_WIDTH - 1)) begin
          cnt_d[c] = '0;
          if (pend_q[c] && !(grant && (gnt_ch == CW'(c)))) begin
            ovr_d[c] = 1'b1;
          end else begin
            hold_d[c] = word_d[c];
            pend_d[c] = 1'b1;
          end
        end else begin
          cnt_d[c] = cnt_q[c] + BW'(1);
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_found) state_d = S_EVAL;
      S_EVAL:  if (walk_end)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready    = (state_q == S_IDLE);
    result_valid = (state_q == S_DONE);
  end

  // Engine datapath: one tree level per EVAL cycle. Children of node n are
  // 2n+1 (value below threshold) and 2n+2; a branch is only taken above the
  // last level, so the shifted node index never overflows.
  always_comb begin
    eval_d    = eval_q;
    node_d    = node_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    res_ch_d  = res_ch_q;
    res_len_d = res_len_q;
    if (grant) begin
      eval_d = hold_q[gnt_ch];
      node_d = '0;
      len_d  = '0;
      ptr_d  = gnt_ch;
    end else if (state_q == S_EVAL) begin
      len_d = len_inc;
      if (walk_end) begin
        res_len_d = len_inc;
        res_ch_d  = ptr_q;
      end else if (eval_q < thr_q[node_q]) begin
        node_d = {node_q[AW-2:0], 1'b1};
      end else begin
        node_d = {node_q[AW-2:0], 1'b0} + AW'(2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        word_q[c] <= '0;
        cnt_q[c]  <= '0;
        hold_q[c] <= '0;
      end
      pend_q <= '0;
      ovr_q  <= '0;
      for (int n = 0; n < NODES; n++) begin
        thr_q[n] <= '0;
      end
      leaf_q    <= '0;
      eval_q    <= '0;
      node_q    <= '0;
      len_q     <= '0;
      ptr_q     <= CW'(NUM_CH - 1);  // channel 0 wins the first arbitration
      res_ch_q  <= '0;
      res_len_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        word_q[c] <= word_d[c];
        cnt_q[c]  <= cnt_d[c];
        hold_q[c] <= hold_d[c];
      end
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      if (cfg_hit) begin
        thr_q[cfg_addr]  <= cfg_thr;
        leaf_q[cfg_addr] <= cfg_leaf;
      end
      eval_q    <= eval_d;
      node_q    <= node_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      res_ch_q  <= res_ch_d;
      res_len_q <= res_len_d;
    end
  end

  assign anomaly_detected = result_valid && (res_len_q < LW'(ANOMALY_LEN));
  assign result_ch        = res_ch_q;
  assign result_len       = res_len_q;
  assign overrun          = ovr_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_i_tree_multi.sv
// ---------------------------------------------------------------------------
// tb_i_tree_multi
//   Self-checking bench for i_tree_multi. A behavioural model tracks each
//   channel's bit count, holding word and pending flag, the node table, and
//   the engine as "busy until edge N". At every grant it walks the tree with
//   plain arithmetic and schedules the expected result edge.
// ---------------------------------------------------------------------------
module tb_i_tree_multi;

  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int ANOM  = 3;
  localparam int NODES = 15;

  // Clock / reset
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT connections
  logic [NCH-1:0] sensor_data, sensor_valid;
  logic           cfg_we;
  logic [3:0]     cfg_addr;
  logic [W-1:0]   cfg_thr;
  logic           cfg_leaf;
  logic           cfg_ready, result_valid, anomaly_detected;
  logic [1:0]     result_ch;
  logic [2:0]     result_len;
  logic [NCH-1:0] overrun;
  logic [1:0]     dbg_state;

  i_tree_multi #(
    .NUM_CH(NCH), .DATA_WIDTH(W), .TREE_DEPTH(DEPTH), .ANOMALY_LEN(ANOM)
  ) dut (
    .clk(clk), .reset(reset),
    .sensor_data(sensor_data), .sensor_valid(sensor_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_thr(cfg_thr), .cfg_leaf(cfg_leaf),
    .cfg_ready(cfg_ready), .result_valid(result_valid), .result_ch(result_ch),
    .result_len(result_len), .anomaly_detected(anomaly_detected),
    .overrun(overrun), .dbg_state_o(dbg_state)
  );

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state
  int          edge_k    = 0;
  int          free_edge = 0;   // first edge at which the engine may grant
  int          m_cnt  [NCH];
  logic [W-1:0] m_word [NCH];
  logic [W-1:0] m_hold [NCH];
  bit          m_pend [NCH];
  logic [NCH-1:0] m_ovr;
  logic [W-1:0] m_thr [NODES];
  bit          m_leaf [NODES];
  int          m_ptr;
  logic [4:0]  exp_q[$];        // {ch, len}
  int          due_q[$];        // edge at which the result goes valid
  logic [1:0]  last_ch;
  logic [2:0]  last_len;

  logic [W-1:0] tx_word [NCH];

  function automatic int walk(input logic [W-1:0] v);
    int node = 0;
    int len  = 0;
    for (int lvl = 1; lvl <= DEPTH; lvl++) begin
      len = lvl;
      if (m_leaf[node] || lvl == DEPTH) break;
      node = (v < m_thr[node]) ? 2 * node + 1 : 2 * node + 2;
    end
    return len;
  endfunction

  task automatic model_step();
    int g;
    int len;
    bit idle;
    logic [W-1:0] gval;
    edge_k++;
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_word[c] = '0; m_hold[c] = '0; m_pend[c] = 0;
      end
      for (int n = 0; n < NODES; n++) begin
        m_thr[n] = '0; m_leaf[n] = 0;
      end
      m_ovr = '0;
      m_ptr = NCH - 1;
      free_edge = edge_k + 1;
      exp_q.delete();
      due_q.delete();
      last_ch = '0;
      last_len = '0;
      return;
    end
    idle = (edge_k >= free_edge);
    g = -1;
    gval = '0;
    if (idle) begin
      for (int i = 1; i <= NCH; i++) begin
        int c;
        c = (m_ptr + i) % NCH;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      gval = m_hold[g];
      m_pend[g] = 0;
    end
    if (cfg_we && idle && cfg_addr < NODES) begin
      m_thr[cfg_addr]  = cfg_thr;
      m_leaf[cfg_addr] = cfg_leaf;
    end
    for (int c = 0; c < NCH; c++) begin
      if (sensor_valid[c]) begin
        m_word[c] = {m_word[c][W-2:0], sensor_data[c]};
        m_cnt[c]++;
        if (m_cnt[c] == W) begin
          m_cnt[c] = 0;
          if (m_pend[c]) m_ovr[c] = 1'b1;
          else begin
            m_hold[c] = m_word[c];
            m_pend[c] = 1;
          end
        end
      end
    end
    if (g >= 0) begin
      len = walk(gval);
      m_ptr = g;
      due_q.push_back(edge_k + len);
      exp_q.push_back({g[1:0], len[2:0]});
      free_edge = edge_k + len + 2;
    end
  endtask

  // One clock: advance model at the edge, compare outputs 1 time unit later.
  task automatic tick();
    bit expv;
    logic [4:0] e;
    int d;
    @(posedge clk);
    model_step();
    #1;
    expv = 0;
    if (due_q.size() > 0 && due_q[0] == edge_k) begin
      expv = 1;
      e = exp_q.pop_front();
      d = due_q.pop_front();
      last_ch = e[4:3];
      last_len = e[2:0];
    end
    check("valid", result_valid, expv);
    check("res_ch", result_ch, last_ch);
    check("res_len", result_len, last_len);
    check("anomaly", anomaly_detected, expv && (last_len < ANOM));
    check("overrun", overrun, m_ovr);
    check("cfg_ready", cfg_ready, (edge_k + 1 >= free_edge));
  endtask

  // Driver tasks
  task automatic quiet();
    sensor_valid = '0; sensor_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_thr = '0; cfg_leaf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic cfg_write(input int addr, input logic [W-1:0] thr, input logic leaf);
    cfg_we = 1'b1; cfg_addr = addr[3:0]; cfg_thr = thr; cfg_leaf = leaf;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic stream(input logic [NCH-1:0] mask);
    for (int b = W - 1; b >= 0; b--) begin
      sensor_valid = mask;
      for (int c = 0; c < NCH; c++) sensor_data[c] = tx_word[c][b];
      tick();
    end
    sensor_valid = '0;
    sensor_data = '0;
  endtask

  task automatic wait_result(input string tag, input int ch, input int len, output int at_edge);
    bit seen;
    seen = 0;
    at_edge = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (result_valid === 1'b1) begin
        seen = 1;
        at_edge = edge_k;
      end
    end
    check({tag, "_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_ch"}, result_ch, ch);
      check({tag, "_len"}, result_len, len);
      check({tag, "_anom"}, anomaly_detected, (len < ANOM));
    end
  endtask

  initial begin
    int c_edge;
    int r0, r1, r2, r3;
    quiet();
    reset = 1'b0;
    tick();
    reset_dut();
    check("rst_valid", result_valid, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_ovr", overrun, 0);
    check("rst_len", result_len, 0);

    // 1: default table, ch0 sends A5. Grant on the edge after completion,
    //    then four EVAL cycles before DONE.
    tx_word[0] = 8'hA5;
    stream(4'b0001);
    c_edge = edge_k;
    wait_result("t1", 0, 4, r0);
    check("t1_lat", r0 - c_edge, 5);

    // 2: root threshold 0x80, node1 leaf.
    idle(3);
    cfg_write(0, 8'h80, 1'b0);
    cfg_write(1, 8'h00, 1'b1);
    tx_word[1] = 8'h10;
    stream(4'b0010);
    wait_result("t2a", 1, 2, r0);
    tx_word[1] = 8'hF0;
    stream(4'b0010);
    wait_result("t2b", 1, 4, r0);

    // 3: all channels complete together after reset; served 0..3, L+2 apart.
    reset_dut();
    tx_word[0] = 8'h11; tx_word[1] = 8'h22; tx_word[2] = 8'h33; tx_word[3] = 8'h44;
    stream(4'b1111);
    wait_result("t3_c0", 0, 4, r0);
    wait_result("t3_c1", 1, 4, r1);
    wait_result("t3_c2", 2, 4, r2);
    wait_result("t3_c3", 3, 4, r3);
    check("t3_gap01", r1 - r0, 6);
    check("t3_gap12", r2 - r1, 6);
    check("t3_gap23", r3 - r2, 6);
    check("t3_ovr", overrun, 0);

    // 4: ch2 completes twice while ch0/ch1 occupy the engine; second is dropped.
    idle(3);
    cfg_write(0, 8'h80, 1'b0);
    cfg_write(1, 8'h00, 1'b1);
    tx_word[0] = 8'h90; tx_word[1] = 8'hA0; tx_word[2] = 8'h20;
    stream(4'b0111);
    tx_word[2] = 8'hC0;
    stream(4'b0100);
    wait_result("t4_c1", 1, 4, r0);
    wait_result("t4_c2", 2, 2, r0);
    check("t4_ovr", overrun, 4'b0100);
    idle(10);
    check("t4_ovr_sticky", overrun, 4'b0100);

    // 5: ch3's second word completes on the edge ch3 is granted.
    //    ch0 granted E0+1, ch1 E0+7, ch3 E0+13; second word ends E0+5+8.
    reset_dut();
    cfg_write(0, 8'h80, 1'b0);
    cfg_write(1, 8'h00, 1'b1);
    tx_word[0] = 8'h90; tx_word[1] = 8'hB0; tx_word[3] = 8'h20;
    stream(4'b1011);
    idle(5);
    tx_word[3] = 8'hC0;
    stream(4'b1000);
    wait_result("t5_old", 3, 2, r0);
    wait_result("t5_new", 3, 4, r1);
    check("t5_ovr", overrun, 0);

    // 6a: a node-table write while busy is ignored.
    idle(3);
    tx_word[0] = 8'h10;
    stream(4'b0001);
    tick();
    cfg_write(1, 8'h00, 1'b0);
    wait_result("t6_busy_we", 0, 2, r0);

    // 6b: reset during EVAL aborts the walk and clears the table.
    idle(3);
    tx_word[0] = 8'hF0;
    stream(4'b0001);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_ready", cfg_ready, 1);
    check("t6_novalid", result_valid, 0);
    idle(8);
    tx_word[0] = 8'h10;
    stream(4'b0001);
    wait_result("t6_cleared", 0, 4, r0);

    // Random traffic, table writes (some out of range) and rare resets.
    for (int i = 0; i < 2500; i++) begin
      sensor_valid = 4'($urandom_range(0, 15));
      sensor_data  = 4'($urandom_range(0, 15));
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_addr = 4'($urandom_range(0, 15));
      cfg_thr  = 8'($urandom_range(0, 255));
      cfg_leaf = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 599) != 0);
      tick();
    end
    quiet();
    reset = 1'b1;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
